led_display_capture: RTL and testbench
======================================

Name: led_display_capture

Overview:
Receiving end of the multiplexed 7-segment scan bus driven by led_display_ctrl. It samples led_display_seg/led_display_sel and reconstructs the per-digit 8-bit segment patterns, i.e. the led_in array on the driver side. It is used by the remote-lab observation path to report the board display state, and by benches as a scoreboard monitor on any display-driving top.

Parameters:
NUM, 8, number of digits (width of led_display_sel)
VALID_SIGNAL, 1'b0, active level of seg and sel lines; must match the driver
STABLE_CYCLES, 16, consecutive clk cycles {seg,sel} must hold unchanged before a capture; must be >= 2
TIMEOUT_CYCLES, 1000000, cycles without a refresh after which a digit is declared dark

Ports:
clk  input  1  system clock, same domain or asynchronous to the display driver
rstn  input  1  asynchronous active-low reset
led_display_seg  input  8  segment lines {dp,g,f,e,d,c,b,a}, active level VALID_SIGNAL
led_display_sel  input  NUM  digit select lines, active level VALID_SIGNAL
led_out  output  [NUM-1:0][7:0]  reconstructed pattern per digit, active-high (1 = segment lit)
led_update  output  1  one-cycle pulse whenever any led_out element changes value
digit_active  output  NUM  bit i = 1 while digit i was refreshed within TIMEOUT_CYCLES
scan_err  output  1  one-cycle pulse when a stable window shows more than one sel bit active

Behaviour:
- Reset (async, rstn=0): led_out all 0, led_update=0, digit_active=0, scan_err=0, synchronisers cleared to the inactive level, FSM in SETTLE, all counters 0.
- Input path: 2-FF synchroniser on all NUM+8 lines. Polarity normalised after sync: XOR with VALID_SIGNAL inverted so that internal 1 = active.
- Stability filter FSM (on the synchronised word s; s_d is s delayed by one cycle):
  SETTLE: if s != s_d then cnt<=0; else cnt<=cnt+1. When s == s_d and cnt == STABLE_CYCLES-2, perform capture and go to HOLD.
  HOLD: stay while s == s_d; on any change cnt<=0 and go to SETTLE. Exactly one capture per stable window.
- Capture decision on the normalised sel:
  - Exactly one bit i set: digit i refreshed, so timeout counter i <= 0 and digit_active[i] <= 1. If seg != led_out[i], then led_out[i] <= seg and led_update pulses in the same cycle.
  - Zero bits set (blanking gap): no action.
  - Two or more bits set: scan_err pulses, no led_out or timeout change.
- Latency: if pins change before clk edge 1 and then hold, led_out/led_update update on edge STABLE_CYCLES+2.
- Glitches shorter than STABLE_CYCLES cycles never cause a capture.
- Timeout: per-digit counter saturating at TIMEOUT_CYCLES. On reaching TIMEOUT_CYCLES: digit_active[i] <= 0, led_out[i] <= 0. led_update pulses only if led_out[i] was nonzero.
- Simultaneous events: a capture on digit i and a timeout on digit i in the same cycle resolve as capture wins. Timeouts on several digits in one cycle produce a single led_update pulse. A capture on digit i and a timeout on digit j (j != i) in the same cycle are both applied, with a single led_update pulse.
- led_update and scan_err are never asserted for more than one consecutive cycle per event.
- Reset mid-operation: all state is discarded immediately. The first capture after release obeys the full latency rule.

Decomposition:
- Shared package led_display_pkg holds:
  - the NUM default
  - typedef seg_t (logic [7:0])
  - 7-segment glyph constants SEG_0..SEG_F and SEG_BLANK, shared with led_display_ctrl and the bench
- One sub-module, led_scan_sampler, contains the synchroniser, polarity normalisation, and stability FSM. It outputs a capture strobe with a {seg,sel} word.
- The top level holds the one-hot check, the led_out registers, and the timeout counters.

Test Plan:
(NUM=8, VALID_SIGNAL=0, STABLE_CYCLES=16, TIMEOUT_CYCLES=1000)
1. Assert rstn=0 mid-stream for 3 cycles -> led_out all 8'h00, digit_active=8'h00, no pulses. First capture after release occurs at edge 18.
2. sel=~8'h01, seg=~8'h3F, held 40 cycles -> led_out[0]=8'h3F at edge 18, a single led_update pulse, digit_active=8'h01.
3. Full scan of 8 glyphs SEG_0..SEG_7, 100 cycles per digit, repeated twice -> led_out matches all glyphs after the first pass. Exactly 8 led_update pulses in total; none in the second pass.
4. Steady digit 2 = 8'h06, then seg toggled to 8'h5B for 10 cycles and back -> no led_update, led_out[2] stays 8'h06.
5. sel=~8'h03 held 40 cycles -> one scan_err pulse, led_out unchanged. sel=8'hFF (none active) -> no pulse.
6. Scan continues on all digits except digit 3, which holds 8'h4F -> about 1000 cycles after its last capture, led_out[3]=8'h00, digit_active[3]=0, one led_update pulse. Other digits are unaffected.

Source files
------------

// File: rtl/led_display_pkg.sv
`default_nettype none
// ============================================================================
// Module  : led_display_pkg
// Brief   : Shared types and 7-segment glyph constants for the LED display
//           scan bus (driver, capture block and benches).
// Revision: 1.0 - initial release
// ============================================================================
package led_display_pkg;

  // Default digit count of the multiplexed display
  localparam int NUM_DEFAULT = 8;

  // Segment pattern {dp,g,f,e,d,c,b,a}, 1 = segment lit
  typedef logic [7:0] seg_t;

  localparam seg_t SEG_0     = 8'h3F;
  localparam seg_t SEG_1     = 8'h06;
  localparam seg_t SEG_2     = 8'h5B;
  localparam seg_t SEG_3     = 8'h4F;
  localparam seg_t SEG_4     = 8'h66;
  localparam seg_t SEG_5     = 8'h6D;
  localparam seg_t SEG_6     = 8'h7D;
  localparam seg_t SEG_7     = 8'h07;
  localparam seg_t SEG_8     = 8'h7F;
  localparam seg_t SEG_9     = 8'h6F;
  localparam seg_t SEG_A     = 8'h77;
  localparam seg_t SEG_B     = 8'h7C;
  localparam seg_t SEG_C     = 8'h39;
  localparam seg_t SEG_D     = 8'h5E;
  localparam seg_t SEG_E     = 8'h79;
  localparam seg_t SEG_F     = 8'h71;
  localparam seg_t SEG_BLANK = 8'h00;

endpackage
`default_nettype wire

// File: rtl/led_scan_sampler.sv
`default_nettype none
// ============================================================================
// Module  : led_scan_sampler
// Brief   : Synchronises the scan bus, normalises polarity to active-high and
//           emits one capture strobe per window in which {seg,sel} held still
//           for STABLE_CYCLES cycles.
// Revision: 1.0 - initial release
// ============================================================================
module led_scan_sampler
  import led_display_pkg::*;
#(
  parameter int   NUM           = NUM_DEFAULT,
  parameter logic VALID_SIGNAL  = 1'b0,
  parameter int   STABLE_CYCLES = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [7:0]     seg_i,
  input  logic [NUM-1:0] sel_i,
  output logic           cap_o,
  output seg_t           cap_seg_o,
  output logic [NUM-1:0] cap_sel_o
);

  localparam int              W        = NUM + 8;
  localparam int              CNT_W    = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 2);
  // Raw pin level meaning "inactive"; also the XOR mask that makes 1 = active
  localparam logic [W-1:0]    INACTIVE = {W{~VALID_SIGNAL}};

  localparam logic [0:0] ST_SETTLE = 1'b0;
  localparam logic [0:0] ST_HOLD   = 1'b1;

  logic [W-1:0]     sync1_q, sync2_q;
  logic [W-1:0]     s, s_dly_q;
  logic             same;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Normalised word: 1 = line active regardless of driver polarity
  assign s    = sync2_q ^ INACTIVE;
  assign same = (s == s_dly_q);

  // Two-flop synchroniser, delayed copy of the word, FSM state and counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync1_q <= INACTIVE;
      sync2_q <= INACTIVE;
      s_dly_q <= '0;
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {seg_i, sel_i};
      sync2_q <= sync1_q;
      s_dly_q <= s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count matching cycles in SETTLE, leave HOLD on any change
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SETTLE: begin
        if (!same) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (!same) begin
          cnt_d   = '0;
          state_d = ST_SETTLE;
        end
      end
      default: begin
        state_d = ST_SETTLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: capture strobe fires on the cycle the window completes
  always_comb begin
    cap_o     = (state_q == ST_SETTLE) && same && (cnt_q == CNT_LAST);
    cap_seg_o = s[W-1:NUM];
    cap_sel_o = s[NUM-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/led_display_capture.sv
`default_nettype none
// ============================================================================
// Module  : led_display_capture
// Brief   : Reconstructs per-digit segment patterns from a multiplexed
//           7-segment scan bus, with per-digit refresh timeout and scan error
//           detection.
// Revision: 1.0 - initial release
// ============================================================================
module led_display_capture
  import led_display_pkg::*;
#(
  parameter int   NUM            = NUM_DEFAULT,
  parameter logic VALID_SIGNAL   = 1'b0,
  parameter int   STABLE_CYCLES  = 16,
  parameter int   TIMEOUT_CYCLES = 1000000
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [7:0]          led_display_seg,
  input  logic [NUM-1:0]      led_display_sel,
  output logic [NUM-1:0][7:0] led_out,
  output logic                led_update,
  output logic [NUM-1:0]      digit_active,
  output logic                scan_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic                    cap;
  seg_t                    cap_seg;
  logic [NUM-1:0]          cap_sel;
  logic                    sel_any, sel_multi;

  logic [NUM-1:0][7:0]     led_q, led_d;
  logic [NUM-1:0]          act_q, act_d;
  logic [NUM-1:0][TMO_W-1:0] tmo_q, tmo_d;
  logic                    upd_q, upd_d;
  logic                    err_q, err_d;

  led_scan_sampler #(
    .NUM           (NUM),
    .VALID_SIGNAL  (VALID_SIGNAL),
    .STABLE_CYCLES (STABLE_CYCLES)
  ) u_sampler (
    .clk       (clk),
    .rstn      (rstn),
    .seg_i     (led_display_seg),
    .sel_i     (led_display_sel),
    .cap_o     (cap),
    .cap_seg_o (cap_seg),
    .cap_sel_o (cap_sel)
  );

  // Clearing the lowest set bit leaves something only if two or more were set
  assign sel_any   = |cap_sel;
  assign sel_multi = |(cap_sel & (cap_sel - NUM'(1)));

  // Per-digit update: a valid refresh takes priority over an expiring timeout
  always_comb begin
    led_d = led_q;
    act_d = act_q;
    tmo_d = tmo_q;
    for (int i = 0; i < NUM; i++) begin
      if (cap && sel_any && !sel_multi && cap_sel[i]) begin
        tmo_d[i] = '0;
        act_d[i] = 1'b1;
        led_d[i] = cap_seg;
      end else if (tmo_q[i] == TMO_LAST) begin
        tmo_d[i] = TMO_MAX;
        act_d[i] = 1'b0;
        led_d[i] = '0;
      end else if (tmo_q[i] != TMO_MAX) begin
        tmo_d[i] = tmo_q[i] + TMO_W'(1);
      end
    end
    // One pulse however many digits change together
    upd_d = (led_d != led_q);
    err_d = cap && sel_multi;
  end

  // Display state, timeout counters and event pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      led_q <= '0;
      act_q <= '0;
      tmo_q <= '0;
      upd_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      led_q <= led_d;
      act_q <= act_d;
      tmo_q <= tmo_d;
      upd_q <= upd_d;
      err_q <= err_d;
    end
  end

  assign led_out      = led_q;
  assign digit_active = act_q;
  assign led_update   = upd_q;
  assign scan_err     = err_q;

endmodule
`default_nettype wire

// File: tb/tb_led_display_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_led_display_capture
// Brief   : Self-checking bench for led_display_capture: directed scenarios
//           plus randomized scan traffic against a behavioural reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_led_display_capture;
  import led_display_pkg::*;

  localparam int NUM    = 8;
  localparam int STABLE = 16;
  localparam int TMO    = 1000;

  logic                clk  = 1'b0;
  logic                rstn = 1'b1;
  logic [7:0]          seg_pins = 8'hFF;
  logic [NUM-1:0]      sel_pins = 8'hFF;
  logic [NUM-1:0][7:0] led_out;
  logic                led_update;
  logic [NUM-1:0]      digit_active;
  logic                scan_err;

  led_display_capture #(
    .NUM            (NUM),
    .VALID_SIGNAL   (1'b0),
    .STABLE_CYCLES  (STABLE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .led_display_seg (seg_pins),
    .led_display_sel (sel_pins),
    .led_out         (led_out),
    .led_update      (led_update),
    .digit_active    (digit_active),
    .scan_err        (scan_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A pin word that has been sampled STABLE times in a row is captured and
  // takes effect two edges later (synchroniser delay); a digit goes dark
  // exactly TMO edges after its last refresh.
  seg_t           m_led [NUM];
  logic [NUM-1:0] m_act;
  logic           m_upd, m_err;
  int             m_last [NUM];
  int             edge_n, run;
  logic [15:0]    m_prev, slot_a, slot_b;
  bit             va, vb;
  bit             model_on = 0;

  task model_reset();
    for (int i = 0; i < NUM; i++) begin
      m_led[i]  = 8'h00;
      m_last[i] = 0;
    end
    m_act = '0; m_upd = 0; m_err = 0;
    edge_n = 0; run = 0; m_prev = '0;
    slot_a = '0; slot_b = '0; va = 0; vb = 0;
  endtask

  task model_step();
    logic [15:0] w, cur;
    bit          cv;
    seg_t        old;
    int          idx;
    edge_n++;
    cv = va; cur = slot_a;
    va = vb; slot_a = slot_b; vb = 0;
    w = ~{seg_pins, sel_pins};
    if (w != m_prev) run = 1;
    else if (run <= STABLE) run++;
    m_prev = w;
    if (run == STABLE) begin
      vb = 1; slot_b = w;
    end
    m_err = 0; idx = -1;
    if (cv) begin
      if ($countones(cur[7:0]) == 1) begin
        for (int i = 0; i < NUM; i++) if (cur[i]) idx = i;
      end else if ($countones(cur[7:0]) > 1) begin
        m_err = 1;
      end
    end
    m_upd = 0;
    for (int i = 0; i < NUM; i++) begin
      old = m_led[i];
      if (i == idx) begin
        m_led[i] = cur[15:8]; m_act[i] = 1'b1; m_last[i] = edge_n;
      end else if (edge_n - m_last[i] == TMO) begin
        m_led[i] = 8'h00; m_act[i] = 1'b0;
      end
      if (m_led[i] != old) m_upd = 1;
    end
  endtask

  function automatic logic [63:0] m_pack();
    logic [63:0] r;
    for (int i = 0; i < NUM; i++) r[i*8 +: 8] = m_led[i];
    return r;
  endfunction

  // Model advances on each edge; outputs compared 1 time unit later
  always begin
    @(posedge clk);
    if (!rstn) model_reset();
    else       model_step();
    #1;
    if (model_on) begin
      chk_eq("led_out", led_out, m_pack());
      chk_eq("digit_active", digit_active, m_act);
      chk_eq("led_update", led_update, m_upd);
      chk_eq("scan_err", scan_err, m_err);
    end
  end

  // Running event counters for the directed scenarios
  int upd_cnt = 0;
  int err_cnt = 0;
  always begin
    @(posedge clk);
    #2;
    if (led_update) upd_cnt++;
    if (scan_err)   err_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  seg_t glyph [16];

  task automatic drive(input logic [7:0] seg_act, input logic [NUM-1:0] sel_act, input int cycles);
    @(negedge clk);
    seg_pins = ~seg_act;
    sel_pins = ~sel_act;
    repeat (cycles) @(posedge clk);
  endtask

  task automatic set_pins(input logic [7:0] seg_act, input logic [NUM-1:0] sel_act);
    seg_pins = ~seg_act;
    sel_pins = ~sel_act;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rstn = 1'b0;
    repeat (cycles) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Edge index (1-based after release) of the first led_update, plus count
  task automatic hold_watch(input int cycles, output int first, output int pulses);
    first = 0; pulses = 0;
    for (int k = 1; k <= cycles; k++) begin
      @(posedge clk);
      #2;
      if (led_update) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
  endtask

  function automatic logic [NUM-1:0] one_hot(input int d);
    logic [NUM-1:0] v;
    v = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  initial begin
    int          first, pulses, p0, e0;
    logic [63:0] exp_led;
    logic [7:0]  g;
    logic [NUM-1:0] sel;
    int          a, b, r;

    glyph = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
              SEG_8, SEG_9, SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F};
    #1 rstn = 1'b0;
    #1 model_on = 1;

    // Digit 0 shows SEG_0 from the first edge after reset release
    set_pins(SEG_0, 8'h01);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    hold_watch(40, first, pulses);
    chk_eq("t2_first_edge", first, 18);
    chk_eq("t2_pulses", pulses, 1);
    chk_eq("t2_led0", led_out[0], 8'h3F);
    chk_eq("t2_active", digit_active, 8'h01);

    // Mid-stream reset: all state cleared, full latency on first capture
    @(negedge clk);
    set_pins(SEG_1, 8'h02);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk_eq("t1_rst_led", led_out, 64'h0);
    chk_eq("t1_rst_active", digit_active, 8'h00);
    chk_eq("t1_rst_pulses", {led_update, scan_err}, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    hold_watch(40, first, pulses);
    chk_eq("t1_first_edge", first, 18);
    chk_eq("t1_led1", led_out[1], 8'h06);

    // Full scan twice from a clean state: eight changes, all in pass one
    set_pins(8'h00, 8'h00);
    do_reset(2);
    p0 = upd_cnt;
    for (int d = 0; d < NUM; d++) drive(glyph[d], one_hot(d), 100);
    chk_eq("t3_pass1_pulses", upd_cnt - p0, 8);
    exp_led = '0;
    for (int d = 0; d < NUM; d++) exp_led[d*8 +: 8] = glyph[d];
    chk_eq("t3_pass1_led", led_out, exp_led);
    p0 = upd_cnt;
    for (int d = 0; d < NUM; d++) drive(glyph[d], one_hot(d), 100);
    chk_eq("t3_pass2_pulses", upd_cnt - p0, 0);
    chk_eq("t3_active", digit_active, 8'hFF);

    // Short glitch on a steady digit is filtered out
    drive(8'h06, one_hot(2), 40);
    p0 = upd_cnt;
    drive(8'h5B, one_hot(2), 10);
    drive(8'h06, one_hot(2), 40);
    chk_eq("t4_pulses", upd_cnt - p0, 0);
    chk_eq("t4_led2", led_out[2], 8'h06);

    // Two selects active -> one scan error; none active -> nothing
    e0 = err_cnt;
    drive(8'h3F, 8'h03, 40);
    chk_eq("t5_multi_err", err_cnt - e0, 1);
    e0 = err_cnt;
    drive(8'h3F, 8'h00, 40);
    chk_eq("t5_none_err", err_cnt - e0, 0);

    // Digit 3 stops being refreshed and goes dark; others keep their glyphs
    p0 = upd_cnt;
    for (int rnd = 0; rnd < 8; rnd++) begin
      for (int d = 0; d < NUM; d++) begin
        if (d != 3) drive((d == 2) ? 8'h06 : glyph[d], one_hot(d), 20);
      end
    end
    chk_eq("t6_led3", led_out[3], 8'h00);
    chk_eq("t6_active", digit_active, 8'hF7);
    chk_eq("t6_pulses", upd_cnt - p0, 1);

    // Randomized traffic: glitches, blanking gaps, multi-select, one reset
    for (int it = 0; it < 160; it++) begin
      r = $urandom_range(0, 9);
      g = 8'($urandom);
      if (r == 0) begin
        sel = '0;
      end else if (r == 1) begin
        a = $urandom_range(0, NUM - 1);
        b = (a + $urandom_range(1, NUM - 1)) % NUM;
        sel = one_hot(a) | one_hot(b);
      end else begin
        sel = one_hot($urandom_range(0, NUM - 1));
      end
      drive(g, sel, $urandom_range(1, 40));
      if (it == 80) do_reset(3);
    end

    // Bus goes idle: every digit times out
    drive(8'h00, 8'h00, TMO + 100);
    chk_eq("idle_active", digit_active, 8'h00);
    chk_eq("idle_led", led_out, 64'h0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
